// File: rtl/deco_3_to_8_strobe.sv
// deco_3_to_8_strobe: FIFO-buffered 3-to-8 decoder that replays each queued code
// as a one-hot strobe held HOLD cycles, separated by GAP zero cycles.
module deco_3_to_8_strobe #(
  parameter int HOLD  = 4,
  parameter int GAP   = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_code,
  input  logic                     en,
  output logic [7:0]               y,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} state_t;
  state_t state, state_d;
  logic [7:0] cnt, cnt_d, y_d;
  logic done_d, push, pop, can_launch, cnt_zero, finish, fire;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign in_ready   = fifo_count != (AW+1)'(DEPTH);
  assign push       = in_valid && in_ready;
  assign can_launch = fifo_count != '0 && en;
  assign cnt_zero   = cnt == '0;
  assign busy       = state != S_IDLE || fifo_count != '0;
  assign finish     = state == S_HOLD && cnt_zero;
  // with no gap the next strobe launches straight out of the last hold cycle
  assign fire = can_launch && (state == S_IDLE ||
                (cnt_zero && (state == S_GAP || (state == S_HOLD && GAP == 0))));
  assign pop = fire;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      y          <= '0;
      done       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      y          <= y_d;
      done       <= done_d;
      wr_ptr     <= wr_ptr + AW'(push);
      rd_ptr     <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end
  always_comb begin
    state_d = fire ? S_HOLD :
              finish ? (GAP > 0 ? S_GAP : S_IDLE) :
              (state == S_GAP && cnt_zero) ? S_IDLE : state;
  end
  always_comb begin
    y_d    = fire ? 8'(1) << mem[rd_ptr] : (state == S_HOLD && !cnt_zero) ? y : 8'h00;
    cnt_d  = fire ? 8'(HOLD - 1) : finish ? 8'(GAP - 1) : cnt_zero ? cnt : cnt - 8'd1;
    done_d = finish;
  end
endmodule

// File: tb/tb_deco_3_to_8_strobe.sv
// tb_deco_3_to_8_strobe: scoreboard bench; drivers queue expected strobes, monitors check them.
module tb_deco_3_to_8_strobe;
  localparam int HOLD = 4, GAP = 1, DEPTH = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, en = 0;
  logic [2:0] in_code = 0;
  logic [7:0] y;
  logic done, busy, in_ready;
  logic [2:0] fifo_count;
  logic v0 = 0, en0 = 1;
  logic [2:0] c0 = 0;
  logic [7:0] y0;
  logic done0, busy0, rdy0;
  logic [2:0] cnt0;
  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0;
  logic [7:0] exp_q[$], exp0_q[$];
  int starts[$];
  logic [7:0] prev_y = 0, prev0 = 0;
  int run = 0;
  bit ended, ended0;
  logic [7:0] tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  deco_3_to_8_strobe #(.HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .en(en), .y(y), .done(done), .busy(busy), .fifo_count(fifo_count));
  deco_3_to_8_strobe #(.HOLD(HOLD), .GAP(0), .DEPTH(DEPTH)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(rdy0), .in_code(c0),
    .en(en0), .y(y0), .done(done0), .busy(busy0), .fifo_count(cnt0));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] e);
    int t = 0;
    in_valid = 1; in_code = c;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) chk("push_timeout", 0, 1);
    else begin
      @(posedge clk); exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || exp_q.size() != 0) && t < 300) begin @(negedge clk); t++; end
    chk("drain_busy", busy, 0);
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic wait_strobe();
    int t = 0;
    while (y == 0 && t < 20) begin @(negedge clk); t++; end
    chk("strobe_timeout", y != 0, 1);
  endtask

  task automatic scen2();
    send(5, tbl[5]); in_valid = 0;
    chk("s2_k0_count", fifo_count, 1);
    @(negedge clk); chk("s2_k1_y", y, 8'h20);
    repeat (3) @(negedge clk);
    chk("s2_k4_y", y, 8'h20); chk("s2_k4_done", done, 0);
    @(negedge clk); chk("s2_k5_y", y, 0); chk("s2_k5_done", done, 1);
    @(negedge clk); chk("s2_k6_busy", busy, 0); chk("s2_k6_done", done, 0);
  endtask

  // main DUT monitor: pop on every strobe start, check hold length and done placement
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_y = 0; run = 0;
    end else begin
      cyc++;
      ended = prev_y != 0 && y != prev_y;
      if (ended) chk("hold_len", run, HOLD);
      if (ended || done) chk("done_at_end", done, ended);
      if (done) done_cnt++;
      if (y != 0 && y != prev_y) begin
        starts.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_strobe", y, 0);
        else chk("strobe_val", y, exp_q.pop_front());
        run = 1;
      end else if (y != 0) run++;
      if (fifo_count == 3'(DEPTH)) chk("full_not_ready", in_ready, 0);
      prev_y = y;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) prev0 = 0;
    else begin
      ended0 = prev0 != 0 && y0 != prev0;
      if (ended0 || done0) chk("g0_done_at_end", done0, ended0);
      if (y0 != 0 && y0 != prev0) begin
        if (exp0_q.size() == 0) chk("g0_unexpected", y0, 0);
        else chk("g0_strobe_val", y0, exp0_q.pop_front());
      end
      prev0 = y0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("in_rst_y", y, 0); chk("in_rst_ready", in_ready, 1);
    rst_n = 1;
    @(negedge clk);
    chk("rst_y", y, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0); chk("rst_ready", in_ready, 1);
    en = 1;
    scen2();
    // back-to-back codes 0..5 with in_valid held high
    starts.delete(); done_cnt = 0;
    for (int i = 0; i < 6; i++) send(3'(i), tbl[i]);
    in_valid = 0;
    drain();
    chk("s3_starts", starts.size(), 6);
    if (starts.size() == 6)
      for (int i = 1; i < 6; i++) chk("s3_spacing", starts[i] - starts[i-1], HOLD + GAP);
    chk("s3_done_cnt", done_cnt, 6);
    // en gating
    en = 0;
    send(1, tbl[1]); send(3, tbl[3]); send(6, tbl[6]); in_valid = 0;
    repeat (3) @(negedge clk);
    chk("s4_y_idle", y, 0); chk("s4_count", fifo_count, 3);
    starts.delete(); done_cnt = 0;
    en = 1;
    wait_strobe();
    @(negedge clk); en = 0;
    repeat (10) @(negedge clk);
    chk("s4_y_off", y, 0); chk("s4_count_left", fifo_count, 2);
    chk("s4_one_start", starts.size(), 1); chk("s4_one_done", done_cnt, 1);
    en = 1;
    drain();
    // GAP=0 instance: codes 2 then 7
    v0 = 1; c0 = 2;
    @(posedge clk); exp0_q.push_back(8'h04);
    @(negedge clk); c0 = 7;
    @(posedge clk); exp0_q.push_back(8'h80);
    @(negedge clk); v0 = 0;
    chk("s5_k1_y", y0, 8'h04);
    repeat (3) @(negedge clk); chk("s5_k4_y", y0, 8'h04); chk("s5_k4_done", done0, 0);
    @(negedge clk); chk("s5_k5_y", y0, 8'h80); chk("s5_k5_done", done0, 1);
    repeat (3) @(negedge clk); chk("s5_k8_y", y0, 8'h80);
    @(negedge clk); chk("s5_k9_y", y0, 0); chk("s5_k9_done", done0, 1);
    @(negedge clk); chk("s5_k10_busy", busy0, 0); chk("s5_left", exp0_q.size(), 0);
    // reset during the second hold cycle with two codes queued
    send(2, tbl[2]); send(4, tbl[4]); send(6, tbl[6]); in_valid = 0;
    chk("s6_y", y, 8'h04); chk("s6_count", fifo_count, 2);
    #2 rst_n = 0;
    #1;
    chk("s6_rst_y", y, 0); chk("s6_rst_count", fifo_count, 0);
    chk("s6_rst_busy", busy, 0); chk("s6_rst_done", done, 0); chk("s6_rst_ready", in_ready, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("s6_post_done", done, 0);
    scen2();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/deco_3_to_8_strobe.md
Name: deco_3_to_8_strobe

Overview:
- Sequential 3-to-8 decoder: the receive-side counterpart of the team's 8:3 encoders.
- Accepts 3-bit codes over a valid/ready handshake and buffers them in a small FIFO.
- Replays each code as a one-hot strobe on an 8-bit output, held for a programmable number of cycles, with a programmable idle gap between strobes.
- Used wherever an encoded select must be expanded back into timed one-hot enables.

Parameters:
HOLD, 4, cycles each one-hot strobe is held (1..255)
GAP, 1, cycles y is forced to zero between consecutive strobes (0..255)
DEPTH, 4, FIFO depth in codes (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_code is valid
in_ready  output  1  FIFO can accept a code (count != DEPTH)
in_code  input  3  code to decode
en  input  1  launch enable for new strobes
y  output  8  one-hot strobe output, registered
done  output  1  one-cycle pulse marking the end of each strobe, registered
busy  output  1  FSM not IDLE or FIFO non-empty
fifo_count  output  $clog2(DEPTH)+1  codes currently queued

Behaviour:
- One clock. Reset is asynchronous and active-low; all state clears immediately on rst_n low.
- Reset values:
  - y=0, done=0, busy=0, fifo_count=0, FSM=IDLE.
  - in_ready=1, because it is combinational from count.
  - Pushes are ignored while rst_n is low.
- Push: occurs at an edge with in_valid && in_ready. in_ready does not look ahead at a same-cycle pop, so a full FIFO accepts nothing that cycle.
- Pop: only at a launch. Push and pop in the same cycle leave fifo_count unchanged.
- Launch condition L: fifo_count!=0 && en.
- Launch action at the edge:
  - y <= 1<<head_code and pop.
  - cnt <= HOLD-1; state <= HOLD.
- IDLE:
  - y=0.
  - If L, launch.
- HOLD:
  - y holds. If cnt!=0, cnt-- each cycle.
  - When cnt==0, at the next edge done<=1 and:
    - GAP>0: y<=0, cnt<=GAP-1, state <= GAP.
    - GAP==0 and L: launch directly. y switches one-hot value with no zero cycle.
    - Otherwise: y<=0, state <= IDLE.
- GAP:
  - y=0. If cnt!=0, cnt--.
  - When cnt==0: launch if L, else go to IDLE.
- Back-to-back strobes start exactly every HOLD+GAP cycles.
- done is high for exactly one cycle after every strobe's final HOLD cycle, in every transition case.
- Latency:
  - Code accepted at edge E0 with FIFO empty and FSM IDLE: y shows the one-hot value after edge E0+1.
  - y stays valid for HOLD cycles and drops (or changes) at edge E0+1+HOLD.
- en low:
  - Blocks launches only.
  - A strobe in progress completes its full HOLD and GAP.
  - Queued codes stay queued.
- All 8 codes are legal; decode is 0->8'h01 ... 7->8'h80. y is never multi-hot.
- FIFO pointers wrap modulo DEPTH. Codes are never dropped or reordered.
- Reset mid-strobe: y drops to 0 asynchronously, the FIFO is flushed, and no done pulse is produced.

Test Plan:
All scenarios use HOLD=4, GAP=1, DEPTH=4.
1. Apply rst_n=0, then release -> y=8'h00, done=0, busy=0, fifo_count=0, in_ready=1.
2. Single in_code=3'd5 accepted at edge E0:
   - y=8'h20 during the 4 cycles after E0+1.
   - y=0 and done=1 for one cycle after E0+5.
   - busy=0 from E0+6.
3. Present codes 0..5 with in_valid held high:
   - in_ready drops whenever fifo_count=4.
   - All 6 codes are accepted in order.
   - y sequence is 01,02,04,08,10,20, each held 4 cycles, one zero cycle between, strobe starts 5 cycles apart.
   - done pulses 6 times.
4. Queue 3 codes with en=0:
   - y stays 0 and fifo_count=3.
   - Raise en: strobes start.
   - Drop en mid-HOLD: the current strobe runs its full 4 cycles and no further launch occurs.
5. Rebuild with GAP=0 and queue codes 2,7:
   - y goes 8'h04 for 4 cycles, then 8'h80 with no zero cycle.
   - done pulses on the cycle the value switches.
6. Assert rst_n low in the 2nd HOLD cycle with 2 codes queued:
   - y=0, fifo_count=0 and busy=0 immediately, with no done pulse.
   - After release, a new code repeats scenario 2 timing.
